multiport_register_file: RTL and testbench

//   Parametrised integer register file for the five-stage core, with a busy-bit scoreboard.
//   N combinational read ports, one synchronous write port, optional write-to-read bypass.

---
 rtl/multiport_register_file_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 46 ++++
 rtl/multiport_register_file.sv | 84 ++++++++
 tb/tb_multiport_register_file.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiport_register_file_pkg.sv
// Shared register-file definitions: default geometry, stack-pointer reset value
// and the hard-zero register index used by decode, hazard unit and this block.
package multiport_register_file_pkg;

  localparam int          RF_DATA_W   = 32;
  localparam int          RF_NUM_REGS = 32;
  localparam int          RF_SP_IDX   = 2;
  localparam logic [31:0] RF_SP_INIT  = 32'h0110_0000;
  localparam int          ZERO_REG    = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one flop per architectural register, set at issue,
// cleared at writeback, wiped by a pipeline flush.
module rf_scoreboard
  import multiport_register_file_pkg::*;
#(
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // NOTE: next-state logic starts from a full default so no path leaves busy_d unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      // A new producer issuing on the same edge outranks the retiring write.
      if (flush)
        busy_d[r] = 1'b0;
      else if (iss_en && iss_rd == ADDR_W'(r))
        busy_d[r] = 1'b1;
      else if (wr_en && wr_addr == ADDR_W'(r))
        busy_d[r] = 1'b0;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/multiport_register_file.sv
// Integer register file: NUM_RD combinational read ports, one write port,
// optional same-cycle write bypass, hard-zero reg 0 and busy scoreboard.
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter  int                DATA_W   = RF_DATA_W,
  parameter  int                NUM_REGS = RF_NUM_REGS,
  parameter  int                NUM_RD   = 2,
  parameter  int                BYPASS   = 1,
  parameter  int                SP_IDX   = RF_SP_IDX,
  parameter  logic [DATA_W-1:0] SP_INIT  = DATA_W'(RF_SP_INIT),
  localparam int                ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_rd,
  input  logic                     flush
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != ADDR_W'(ZERO_REG))
      regs_d[wr_addr] = wr_data;
  end

  // NOTE: the storage array is reset on purpose: every index must read a defined value after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clock   (clock),
    .reset_n (reset_n),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .flush   (flush),
    .busy    (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy_bit;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    // A forwarded value is the retiring result, so it cannot still be pending.
    always_comb begin
      data     = regs_q[addr];
      busy_bit = busy[addr];
      if (addr == ADDR_W'(ZERO_REG)) begin
        data     = '0;
        busy_bit = 1'b0;
      end else if (BYPASS != 0 && wr_en && wr_addr == addr) begin
        data     = wr_data;
        busy_bit = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy_bit;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: default instance (32x32, 2 ports, bypass) and a
// 16x64, 4-port instance without bypass.
module tb_multiport_register_file;

  localparam logic [63:0] SP_VAL = 64'h0000_0000_0110_0000;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Instance a: defaults
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en, a_iss_en, a_flush;
  logic [4:0]  a_wr_addr, a_iss_rd;
  logic [31:0] a_wr_data;

  // Instance b: NUM_REGS=16, DATA_W=64, NUM_RD=4, BYPASS=0
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_wr_en, b_iss_en, b_flush;
  logic [3:0]   b_wr_addr, b_iss_rd;
  logic [63:0]  b_wr_data;

  multiport_register_file dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .rd_addr (a_rd_addr),
    .rd_data (a_rd_data),
    .rd_busy (a_rd_busy),
    .wr_en   (a_wr_en),
    .wr_addr (a_wr_addr),
    .wr_data (a_wr_data),
    .iss_en  (a_iss_en),
    .iss_rd  (a_iss_rd),
    .flush   (a_flush)
  );

  multiport_register_file #(
    .DATA_W   (64),
    .NUM_REGS (16),
    .NUM_RD   (4),
    .BYPASS   (0)
  ) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .rd_addr (b_rd_addr),
    .rd_data (b_rd_data),
    .rd_busy (b_rd_busy),
    .wr_en   (b_wr_en),
    .wr_addr (b_wr_addr),
    .wr_data (b_wr_data),
    .iss_en  (b_iss_en),
    .iss_rd  (b_iss_rd),
    .flush   (b_flush)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_idle();
    a_wr_en  = 1'b0;
    a_iss_en = 1'b0;
    a_flush  = 1'b0;
  endtask

  task automatic b_idle();
    b_wr_en  = 1'b0;
    b_iss_en = 1'b0;
    b_flush  = 1'b0;
  endtask

  function automatic logic [31:0] a_data(input int k);
    return a_rd_data[k*32 +: 32];
  endfunction

  function automatic logic [63:0] b_data(input int k);
    return b_rd_data[k*64 +: 64];
  endfunction

  initial begin
    reset_n   = 1'b0;
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_iss_rd = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_iss_rd = '0;
    a_idle();
    b_idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    // 1. reset contents of every index, both instances
    for (int i = 0; i < 32; i++) begin
      a_rd_addr = {5'(31 - i), 5'(i)};
      #1;
      check($sformatf("a_rst_r%0d", i), 64'(a_data(0)), (i == 2) ? SP_VAL : 64'h0);
      check($sformatf("a_rst_r%0d", 31 - i), 64'(a_data(1)), (31 - i == 2) ? SP_VAL : 64'h0);
      check($sformatf("a_rst_busy_%0d", i), 64'(a_rd_busy), 64'h0);
    end
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) b_rd_addr[k*4 +: 4] = 4'((i + k) % 16);
      #1;
      for (int k = 0; k < 4; k++)
        check($sformatf("b_rst_r%0d", (i + k) % 16), b_data(k), ((i + k) % 16 == 2) ? SP_VAL : 64'h0);
      check($sformatf("b_rst_busy_%0d", i), 64'(b_rd_busy), 64'h0);
    end

    // 2. write reg5: bypass same cycle on a, next cycle on b
    a_rd_addr = {5'd5, 5'd0};
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEAD_BEEF;
    #1;
    check("a_bypass_r5", 64'(a_data(1)), 64'hDEAD_BEEF);
    tick();
    a_idle();
    #1;
    check("a_stored_r5", 64'(a_data(1)), 64'hDEAD_BEEF);

    b_rd_addr = 16'h0050;
    b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 64'hDEAD_BEEF;
    #1;
    check("b_nobypass_old_r5", b_data(1), 64'h0);
    tick();
    b_idle();
    #1;
    check("b_next_cycle_r5", b_data(1), 64'hDEAD_BEEF);

    // 3. reg0 write and issue to reg0 have no effect
    a_rd_addr = '0;
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFF_FFFF;
    a_iss_en = 1'b1; a_iss_rd = 5'd0;
    #1;
    check("a_r0_data_during_wr", 64'(a_data(0)), 64'h0);
    check("a_r0_busy_during_wr", 64'(a_rd_busy), 64'h0);
    tick();
    a_idle();
    #1;
    check("a_r0_data_after", 64'(a_data(1)), 64'h0);
    check("a_r0_busy_after", 64'(a_rd_busy), 64'h0);

    // 4. busy set, set+clear same edge, then clear
    a_rd_addr = {5'd0, 5'd7};
    a_iss_en = 1'b1; a_iss_rd = 5'd7;
    #1;
    check("a_busy7_before_edge", 64'(a_rd_busy[0]), 64'h0);
    tick();
    a_idle();
    #1;
    check("a_busy7_set", 64'(a_rd_busy[0]), 64'h1);
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h0000_0077;
    a_iss_en = 1'b1; a_iss_rd = 5'd7;
    #1;
    check("a_busy7_bypass", 64'(a_rd_busy[0]), 64'h0);
    check("a_data7_bypass", 64'(a_data(0)), 64'h77);
    tick();
    a_idle();
    #1;
    check("a_busy7_set_wins", 64'(a_rd_busy[0]), 64'h1);
    check("a_data7_written_while_busy", 64'(a_data(0)), 64'h77);
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h0000_0078;
    tick();
    a_idle();
    #1;
    check("a_busy7_cleared", 64'(a_rd_busy[0]), 64'h0);
    check("a_data7_second", 64'(a_data(0)), 64'h78);

    // 5. issue 3, 9, 12 then flush with a same-edge issue to 4
    a_iss_en = 1'b1;
    a_iss_rd = 5'd3;  tick();
    a_iss_rd = 5'd9;  tick();
    a_iss_rd = 5'd12; tick();
    a_idle();
    a_rd_addr = {5'd12, 5'd3};
    #1;
    check("a_busy_3_12", 64'(a_rd_busy), 64'h3);
    a_rd_addr = {5'd4, 5'd9};
    #1;
    check("a_busy_9_not4", 64'(a_rd_busy), 64'h1);
    a_flush = 1'b1; a_iss_en = 1'b1; a_iss_rd = 5'd4;
    tick();
    a_idle();
    #1;
    check("a_flush_9_4", 64'(a_rd_busy), 64'h0);
    a_rd_addr = {5'd12, 5'd3};
    #1;
    check("a_flush_3_12", 64'(a_rd_busy), 64'h0);

    // 6. asynchronous reset mid-cycle with a write and issue pending
    a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'h66;
    b_wr_en = 1'b1; b_wr_addr = 4'd6; b_wr_data = 64'h66;
    tick();
    a_wr_addr = 5'd2; a_wr_data = 32'h1234;
    b_wr_addr = 4'd2; b_wr_data = 64'h1234;
    tick();
    a_idle(); b_idle();
    a_iss_en = 1'b1; a_iss_rd = 5'd6;
    b_iss_en = 1'b1; b_iss_rd = 4'd6;
    tick();
    a_rd_addr = {5'd2, 5'd6};
    b_rd_addr = {4'd2, 4'd6, 4'd2, 4'd6};
    a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'hAA;
    b_wr_en = 1'b1; b_wr_addr = 4'd6; b_wr_data = 64'hAA;
    #1;
    check("a_pre_rst_r2", 64'(a_data(1)), 64'h1234);
    check("b_pre_rst_r6", b_data(0), 64'h66);
    check("b_pre_rst_busy6", 64'(b_rd_busy[0]), 64'h1);
    reset_n = 1'b0;
    #1;
    check("a_async_rst_r2", 64'(a_data(1)), SP_VAL);
    check("b_async_rst_r6", b_data(0), 64'h0);
    check("b_async_rst_busy", 64'(b_rd_busy), 64'h0);
    check("b_async_rst_r2", b_data(1), SP_VAL);
    tick();
    a_idle(); b_idle();
    #1;
    check("a_rst_edge_r6", 64'(a_data(0)), 64'h0);
    check("a_rst_edge_busy", 64'(a_rd_busy), 64'h0);
    check("b_rst_edge_r6", b_data(2), 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("a_post_rst_r6", 64'(a_data(0)), 64'h0);
    check("a_post_rst_r2", 64'(a_data(1)), SP_VAL);
    check("b_post_rst_r6", b_data(0), 64'h0);
    check("b_post_rst_busy", 64'(b_rd_busy), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
